// File: rtl/serial_pattern_tx_if.sv
// serial_pattern_tx_if
// Bundles the control and serial-line signals of serial_pattern_tx.
//   master : stimulus side. Drives start/pattern/len/loop and observes w/busy/done/bit_idx.
//   slave  : transmitter side.
// Signals:
//   start   : launch request (level)
//   pattern : WIDTH-bit pattern to send
//   len     : number of bits to send
//   loop    : request to repeat the frame
//   w       : serial output line
//   busy    : high while a frame is sending or in its gap
//   done    : one-cycle pulse at the end of a frame
//   bit_idx : index of the bit currently on w
interface serial_pattern_tx_if #(
   parameter int WIDTH = 8,
   parameter int LW    = $clog2(WIDTH + 1)
);
   logic             start;
   logic [WIDTH-1:0] pattern;
   logic [LW-1:0]    len;
   logic             loop;
   logic             w;
   logic             busy;
   logic             done;
   logic [LW-1:0]    bit_idx;

   modport master (output start, pattern, len, loop,
                   input  w, busy, done, bit_idx);
   modport slave  (input  start, pattern, len, loop,
                   output w, busy, done, bit_idx);
endinterface

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx
// Sends pattern[len-1:0] MSB-first on the single-bit line w. Each bit is held for
// BIT_TICKS clocks. Every frame is followed by a low guard gap of BIT_TICKS clocks.
// Optional feature: define SERIAL_TX_LOOP_EN to repeat the captured frame while
// loop=1. loop is sampled in the last gap cycle. In the default build loop is ignored.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : serial_pattern_tx_if.slave, which carries the following signals
//           start, pattern, len, loop : inputs
//           w, busy, done, bit_idx    : outputs, all registered
module serial_pattern_tx #(
   parameter  int WIDTH     = 8,
   parameter  int BIT_TICKS = 4,
   localparam int LW        = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   serial_pattern_tx_if.slave bus
);
   localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [LW-1:0]    len_q, len_d;
   logic [LW-1:0]    idx_q, idx_d;
   logic [TW-1:0]    tick_q, tick_d;
   logic             w_q, w_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic loop_en;
`ifdef SERIAL_TX_LOOP_EN
   assign loop_en = bus.loop;
`else
   assign loop_en = 1'b0;
`endif

   // len is only accepted when it lies in 1..WIDTH. Out-of-range values leave the block idle.
   logic len_ok;
   assign len_ok = (bus.len != '0) && (bus.len <= LW'(WIDTH));

   logic tick_last;
   assign tick_last = (tick_q == TW'(BIT_TICKS - 1));

   // Shift the pattern and read bit 0. This avoids an index that is wider than the vector needs.
   function automatic logic bit_at(input logic [WIDTH-1:0] p, input logic [LW-1:0] i);
      logic [WIDTH-1:0] s;
      s = p >> i;
      return s[0];
   endfunction

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      len_d   = len_q;
      idx_d   = idx_q;
      tick_d  = tick_q;
      w_d     = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            idx_d  = '0;
            tick_d = '0;
            if (bus.start && len_ok) begin
               state_d = SEND;
               pat_d   = bus.pattern;
               len_d   = bus.len;
               idx_d   = bus.len - LW'(1);
               w_d     = bit_at(bus.pattern, bus.len - LW'(1));
               busy_d  = 1'b1;
            end
         end
         SEND: begin
            if (tick_last) begin
               tick_d = '0;
               if (idx_q != '0) begin
                  idx_d = idx_q - LW'(1);
                  w_d   = bit_at(pat_q, idx_q - LW'(1));
               end else begin
                  state_d = GAP;
                  idx_d   = '0;
               end
            end else begin
               tick_d = tick_q + TW'(1);
               w_d    = w_q;
            end
         end
         GAP: begin
            if (tick_last) begin
               tick_d = '0;
               done_d = 1'b1;
               if (loop_en) begin
                  // Restart from the captured frame. busy stays high, and done is
                  // raised in the same cycle as the first bit of the new frame.
                  state_d = SEND;
                  idx_d   = len_q - LW'(1);
                  w_d     = bit_at(pat_q, len_q - LW'(1));
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            idx_d   = '0;
            tick_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         pat_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         tick_q  <= '0;
         w_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         tick_q  <= tick_d;
         w_q     <= w_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.w       = w_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.bit_idx = idx_q;
endmodule

// File: tb/tb_serial_pattern_tx.sv
module tb_serial_pattern_tx;
   localparam int WIDTH = 8;
   localparam int BT    = 2;
   localparam int LW    = $clog2(WIDTH + 1);

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   serial_pattern_tx_if #(.WIDTH(WIDTH)) bus ();

   serial_pattern_tx #(.WIDTH(WIDTH), .BIT_TICKS(BT)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Advance one clock. Outputs are sampled 1ns after the edge, and inputs are changed there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Observed vector layout: {w, busy, done, bit_idx}.
   task automatic test_reset();
      logic [LW+2:0] obs, exp;
      reset = 1'b0;
      bus.start = 1'b1; bus.pattern = 8'h0B; bus.len = 4'd4; bus.loop = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         step();
         obs = {bus.w, bus.busy, bus.done, bus.bit_idx};
         exp = '0;
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL reset cyc=%0d got=%b exp=%b", k, obs, exp);
         end
      end
      bus.start = 1'b0;
      reset = 1'b1;
      step();
   endtask

   // A single frame of 0x0B/len 4. With churn=1, pattern and start are changed mid-frame.
   task automatic test_single_frame(input bit churn);
      logic [10:0] w_exp;
      logic [LW-1:0] idx_exp [11];
      logic [LW+2:0] obs, exp;
      w_exp   = 11'b11001111000;
      idx_exp = '{4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      bus.pattern = 8'h0B; bus.len = 4'd4; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         if (k <= 11)
            exp = {w_exp[11-k], (k <= 10), (k == 11), idx_exp[k-1]};
         else
            exp = '0;
         obs = {bus.w, bus.busy, bus.done, bus.bit_idx};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", churn ? "churn" : "single", k, obs, exp);
         end
         if (churn && k == 3) begin bus.pattern = 8'hFF; bus.len = 4'd8; bus.start = 1'b1; end
         if (churn && k == 5) bus.start = 1'b0;
         step();
      end
   endtask

   // Out-of-range lengths must leave the block idle.
   task automatic test_bad_len();
      logic [LW-1:0] lens [2];
      logic [LW+2:0] obs;
      lens = '{4'd0, 4'd9};
      bus.pattern = 8'hFF;
      for (int j = 0; j < 2; j++) begin
         bus.len = lens[j]; bus.start = 1'b1;
         for (int k = 1; k <= 3; k++) begin
            step();
            obs = {bus.w, bus.busy, bus.done, bus.bit_idx};
            checks++;
            if (obs !== '0) begin
               failures++;
               $display("FAIL bad_len len=%0d cyc=%0d got=%b exp=0", lens[j], k, obs);
            end
         end
      end
      bus.start = 1'b0;
      step();
   endtask

   // start held high with a 1-bit frame gives a period of 5 cycles.
   task automatic test_back_to_back();
      logic [LW+2:0] obs, exp;
      int p;
      bus.pattern = 8'h01; bus.len = 4'd1; bus.start = 1'b1;
      step();
      for (int k = 1; k <= 16; k++) begin
         p = (k - 1) % 5;
         exp = (k == 16) ? '0 : {(p < 2), (p < 4), (p == 4), 4'd0};
         obs = {bus.w, bus.busy, bus.done, bus.bit_idx};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL back_to_back cyc=%0d got=%b exp=%b", k, obs, exp);
         end
         if (k == 14) bus.start = 1'b0;
         step();
      end
   endtask

   // A reset in the middle of a frame aborts it without a done pulse.
   task automatic test_mid_reset();
      logic [LW+2:0] obs, exp;
      bus.pattern = 8'hFF; bus.len = 4'd8; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         exp = {1'b1, 1'b1, 1'b0, (k <= 2) ? 4'd7 : (k <= 4) ? 4'd6 : 4'd5};
         obs = {bus.w, bus.busy, bus.done, bus.bit_idx};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL mid_reset_pre cyc=%0d got=%b exp=%b", k, obs, exp);
         end
         if (k < 5) step();
      end
      reset = 1'b0;
      step();
      reset = 1'b1;
      for (int k = 6; k <= 9; k++) begin
         obs = {bus.w, bus.busy, bus.done, bus.bit_idx};
         checks++;
         if (obs !== '0) begin
            failures++;
            $display("FAIL mid_reset_post cyc=%0d got=%b exp=0", k, obs);
         end
         step();
      end
   endtask

   // 0x02/len 2 with loop=1. The loop build repeats the frame. The default build sends one frame only.
   task automatic test_loop();
      logic [LW+2:0] obs, exp;
      logic [2:0] e;
      int p;
      bus.pattern = 8'h02; bus.len = 4'd2; bus.loop = 1'b1; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int k = 1; k <= 14; k++) begin
`ifdef SERIAL_TX_LOOP_EN
         p = (k - 1) % 6;
         if (k <= 12)      e = {(p < 2), 1'b1, (p == 0 && k > 1)};
         else if (k == 13) e = 3'b001;
         else              e = 3'b000;
`else
         p = k - 1;
         if (k <= 6)       e = {(p < 2), 1'b1, 1'b0};
         else if (k == 7)  e = 3'b001;
         else              e = 3'b000;
`endif
         exp = {e, 4'd0};
         obs = {bus.w, bus.busy, bus.done, 4'd0};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL loop cyc=%0d got=%b exp=%b", k, obs, exp);
         end
         if (k == 8) bus.loop = 1'b0;
         step();
      end
   endtask

   initial begin
      reset = 1'b0;
      bus.start = 1'b0; bus.pattern = '0; bus.len = '0; bus.loop = 1'b0;
      test_reset();
      test_single_frame(1'b0);
      test_single_frame(1'b1);
      test_bad_len();
      test_back_to_back();
      test_mid_reset();
      test_loop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial pattern transmitter: captures a WIDTH-bit pattern and a bit count, then drives it MSB-first onto a single-bit serial line `w`, holding each bit for BIT_TICKS clocks. A forced low guard gap follows every frame. It is the producing end of the single-bit `w` input that our sequence-detecting FSMs consume, and replaces hand-toggled switch stimulus on the board and in lab benches. It runs on the same selected clock (`clk`) as the downstream FSM.

## Interface
- WIDTH, 8, maximum pattern length in bits (2..32)
- BIT_TICKS, 4, clock cycles each bit (and the gap) is held (1..256)
- LW, $clog2(WIDTH+1), width of `len` (derived; do not override)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low; reset=0 at a rising edge of `clk` resets the block
- start  input  1  level; sampled only in IDLE; launches a frame
- pattern  input  WIDTH  bits to send; `pattern[len-1:0]` is transmitted
- len  input  LW  number of bits to send, 1..WIDTH; 0 = no-op
- loop  input  1  repeat frame continuously (effective only with SERIAL_TX_LOOP_EN)
- w  output  1  serial data line
- busy  output  1  high during SEND and GAP
- done  output  1  one-cycle pulse after a frame's gap completes
- bit_idx  output  LW  index of the bit currently on `w`; 0 when not in SEND

## Operation
- States: IDLE, SEND, GAP.
- IDLE: `w`=0, `busy`=0, `bit_idx`=0.
  - If `start`=1 and 1 ≤ `len` ≤ WIDTH: capture `pattern` into a shift register and `len` into a bit counter; go to SEND.
  - If `len`=0 or `len`>WIDTH: `start` is ignored, stay in IDLE, no `done`.
- SEND: `w` = captured bit [`bit_idx`], starting at `bit_idx`=`len`-1 and counting down to 0. A tick counter (0..BIT_TICKS-1) advances each cycle. When the tick counter reaches BIT_TICKS-1:
  - if `bit_idx`>0: decrement `bit_idx` and reset the tick counter;
  - if `bit_idx`=0: go to GAP.
- GAP: `w`=0 for BIT_TICKS cycles. At the end of the gap:
  - with looping active, reload `bit_idx`=captured `len`-1 and return to SEND;
  - otherwise go to IDLE.
  - `done` pulses in either case.
- `start`, `pattern` and `len` are ignored while `busy`=1. Captured values are immune to mid-frame input changes.
- `start` held high in IDLE relaunches immediately after `done`. Successive frames are separated only by the gap.
- Reset mid-frame: abort with no `done`. All outputs take their reset values at that edge.

## Timing
- Reset values: `w`=0, `busy`=0, `done`=0, `bit_idx`=0, state IDLE, counters 0.
- All outputs are registered.
- `start` sampled high at edge E0:
  - `busy`=1 and the first bit appears on `w` in the cycle after E0;
  - latency is 1 cycle.
- `busy` stays high for exactly (`len`+1)·BIT_TICKS cycles.
- `done`=1 for the single cycle immediately after `busy` falls. In loop mode, `busy` stays 1 and `done` is coincident with the first cycle of the next frame.
- Back-to-back with `start` held: the next frame's first bit appears in the cycle after `done`. Frame period is (`len`+1)·BIT_TICKS+1 cycles.
- BIT_TICKS=1 degenerates to one bit per clock. No special casing is permitted.

## Configuration
- SERIAL_TX_LOOP_EN defined:
  - `loop` is sampled at the last GAP cycle;
  - `loop`=1 repeats the captured frame without visiting IDLE;
  - `loop`=0 finishes normally.
- SERIAL_TX_LOOP_EN undefined:
  - `loop` is unconnected internally and ignored;
  - every frame ends in IDLE.
- The port list is identical in both builds.

## Test plan
All scenarios use WIDTH=8 and BIT_TICKS=2.
- Reset/idle: hold `reset`=0 for 2 cycles with `start`=1 → `w`=0, `busy`=0, `done`=0 throughout.
- Single frame: `pattern`=8'h0B, `len`=4, `start` pulse at E0 →
  - cycles 1–8: `w`=1,1,0,0,1,1,1,1;
  - `bit_idx`=3,3,2,2,1,1,0,0;
  - cycles 9–10: `w`=0;
  - `busy` high over cycles 1–10;
  - `done`=1 in cycle 11 only.
- Input churn/ignored start: during the frame above, change `pattern` to 8'hFF and pulse `start` → identical `w` sequence and a single `done`. A separate `start` with `len`=0 → no `busy`, no `done`.
- Back-to-back: `start` held, `pattern`=8'h01, `len`=1 → `w` 1,1,0,0 repeating with period 5 cycles, `done` every 5th cycle.
- Mid-frame reset: `len`=8, `pattern`=8'hFF, `reset`=0 at cycle 5 → `w`=0, `busy`=0 from the following cycle, no `done`.
- Loop (SERIAL_TX_LOOP_EN defined): `loop`=1, `pattern`=8'h02, `len`=2 →
  - `w` 1,1,0,0,0,0 repeating;
  - `busy` never drops;
  - `done` at each frame boundary;
  - dropping `loop` ends after the current frame.
  - Same stimulus without the macro → a single frame, then IDLE.
